apb_regbank_slave: RTL and testbench
====================================

APB_REGBANK_SLAVE -- requirements
Module: apb_regbank_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning PADDR width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning PWDATA/PRDATA width; it must be a multiple of 8.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the number of word registers, 1..2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter WAIT_STATES, default 2, meaning PREADY-low access cycles per transfer, 0..15.
REQ-005 The block SHALL have the following ports:
- PCLK  in  1  the single clock; all state changes on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  word index.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write strobes (present only with REQ-019 macro).
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  transfer error, valid only while PREADY=1.

Function
REQ-006 The FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE->SETUP on PSEL=1, PENABLE=0.
- SETUP->ACCESS unconditionally.
- ACCESS->IDLE on completion or abort.
REQ-007 On the SETUP edge the block SHALL latch PADDR, PWRITE, PWDATA and PSTRB, and load the wait counter with WAIT_STATES.
REQ-008 In ACCESS the wait counter SHALL decrement each cycle while non-zero; PREADY SHALL be 1 exactly in the ACCESS cycle where the counter is 0, giving WAIT_STATES+1 access cycles per transfer (1 when WAIT_STATES=0).
REQ-009 A write SHALL commit to the register on the clock edge ending the PREADY=1 cycle, and only if the latched address < DEPTH.
REQ-010 A read SHALL present the register content in PRDATA (registered) for the entire PREADY=1 cycle; otherwise PRDATA SHALL hold its last value.
REQ-011 A latched address >= DEPTH SHALL produce PSLVERR=1 with PREADY=1: no register change, and PRDATA=0 for reads.
REQ-012 PSEL=0 during ACCESS before completion SHALL abort the transfer to IDLE with no write, and PREADY and PSLVERR SHALL stay 0.
REQ-013 PENABLE=1 while in IDLE SHALL be ignored (no PREADY); every transfer requires a SETUP cycle, including back-to-back transfers.
REQ-014 PREADY and PSLVERR SHALL be 0 in IDLE and SETUP.
REQ-015 Changes to PADDR, PWRITE or PWDATA during ACCESS SHALL be ignored; the latched values from REQ-007 govern.

Reset
REQ-016 PRESET=1 SHALL force, asynchronously: state IDLE, wait counter 0, PREADY=0, PSLVERR=0, PRDATA=0, and all registers 0.
REQ-017 Reset asserted mid-transfer SHALL discard the transfer; no partial write SHALL survive.
REQ-018 After PRESET deasserts, the first transfer SHALL be accepted at the first SETUP cycle.

Configuration
REQ-019 With APB_SLAVE_PSTRB_EN defined, the PSTRB port SHALL exist, and a write SHALL update only the bytes whose strobe bit is 1; all-zero PSTRB SHALL complete normally with no change.
REQ-020 Without APB_SLAVE_PSTRB_EN, the PSTRB port SHALL be absent and every write SHALL update the full word.
REQ-021 Reads SHALL ignore PSTRB in both configurations.

Structure
REQ-022 Package apb_regbank_pkg SHALL hold the FSM state enum, the wait-counter width constant (4) and the function deriving the strobe width from DATA_WIDTH.
REQ-023 Register storage with byte-enable write SHALL be a sub-module named apb_regbank_mem; the FSM, wait counter and error decode SHALL live in the top.

Verification
REQ-024 The bench SHALL cover: WAIT_STATES=2; write 16'hFFFF to addr 0, then read addr 0 -> PREADY high on the 3rd ACCESS cycle each time, PRDATA=16'hFFFF, PSLVERR=0.
REQ-025 The bench SHALL cover: write 16'hEACF to addr 1, then read addr 0 and addr 1 -> 16'hFFFF and 16'hEACF respectively.
REQ-026 The bench SHALL cover: DEPTH=16, write to addr 8'h20 -> PREADY=1 with PSLVERR=1, no register changed; read of 8'h20 -> PRDATA=0, PSLVERR=1.
REQ-027 The bench SHALL cover: APB_SLAVE_PSTRB_EN defined, addr 2 holding 16'h1234, write 16'hABCD with PSTRB=2'b10 -> read returns 16'hAB34.
REQ-028 The bench SHALL cover: PSEL dropped in the 2nd ACCESS cycle of a write of 16'h5555 to addr 3 -> no PREADY, addr 3 reads 0.
REQ-029 The bench SHALL cover: PRESET pulsed mid-wait -> PREADY, PSLVERR and PRDATA go to 0 immediately, all registers read 0, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_regbank_pkg.sv
// Shared types and constants for the APB register-bank slave.
package apb_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_regbank_mem.sv
// Word register array with byte-enable write and a combinational read port.
// Out-of-range read addresses return zero.
module apb_regbank_mem
    import apb_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]   wstrb,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    output logic [DATA_WIDTH-1:0]               rdata
);

    localparam int STRB_W = strb_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];

    // Register storage: cleared by reset, byte-granular update on write enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == ADDR_WIDTH'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb[b]) begin
                            regs_r[i][8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux built as an AND-OR tree so an unmatched address yields zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdata = rdata | (regs_r[i] & {DATA_WIDTH{raddr == ADDR_WIDTH'(i)}});
        end
    end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave fronting a word register bank with fixed wait states.
// Optional byte strobes are enabled by defining APB_SLAVE_PSTRB_EN.
module apb_regbank_slave
    import apb_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                                PCLK,
    input  logic                                PRESET,
    input  logic                                PSEL,
    input  logic                                PENABLE,
    input  logic                                PWRITE,
    input  logic [ADDR_WIDTH-1:0]               PADDR,
    input  logic [DATA_WIDTH-1:0]               PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
    input  logic [strb_width(DATA_WIDTH)-1:0]   PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]               PRDATA,
    output logic                                PREADY,
    output logic                                PSLVERR
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e              state_r;
    apb_state_e              state_s;
    logic [WAIT_CNT_W-1:0]   cnt_r;
    logic [WAIT_CNT_W-1:0]   cnt_s;
    logic                    setup_s;
    logic                    pready_s;
    logic                    addr_ok_s;
    logic                    mem_we_s;
    logic [STRB_W-1:0]       strb_in_s;
    logic [DATA_WIDTH-1:0]   rdata_s;

    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [STRB_W-1:0]       strb_r;
    logic                    pready_r;
    logic                    pslverr_r;
    logic [DATA_WIDTH-1:0]   prdata_r;

`ifdef APB_SLAVE_PSTRB_EN
    assign strb_in_s = PSTRB;
`else
    assign strb_in_s = {STRB_W{1'b1}};
`endif

    assign addr_ok_s = (32'(addr_r) < 32'(DEPTH));
    assign mem_we_s  = (state_r == ST_ACCESS) && pready_r && write_r && addr_ok_s;

    // Next-state and wait-counter logic; PREADY is precomputed for the next cycle
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        setup_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_s = ST_SETUP;
                    cnt_s   = WAIT_LOAD;
                    setup_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else if (!PSEL) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r - WAIT_CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        pready_s = (state_s == ST_ACCESS) && (cnt_s == '0);
    end

    // FSM state and wait counter
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Transfer attributes captured on entry to SETUP; bus changes afterwards are ignored
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            addr_r  <= '0;
            write_r <= 1'b0;
            wdata_r <= '0;
            strb_r  <= '0;
        end else if (setup_s) begin
            addr_r  <= PADDR;
            write_r <= PWRITE;
            wdata_r <= PWDATA;
            strb_r  <= strb_in_s;
        end
    end

    // Registered response; PRDATA only changes when a read completes
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            pready_r  <= pready_s;
            pslverr_r <= pready_s && !addr_ok_s;
            if (pready_s && !write_r) begin
                prdata_r <= addr_ok_s ? rdata_s : '0;
            end
        end
    end

    apb_regbank_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we_s),
        .waddr (addr_r),
        .wdata (wdata_r),
        .wstrb (strb_r),
        .raddr (addr_r),
        .rdata (rdata_s)
    );

    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;
    assign PRDATA  = prdata_r;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Self-checking bench for apb_regbank_slave: directed scenarios plus random
// transfers against an array-based register model. Honours APB_SLAVE_PSTRB_EN.
module tb_apb_regbank_slave;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int WS    = 2;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [1:0]    PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rd;

    apb_regbank_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
`ifdef APB_SLAVE_PSTRB_EN
        .PSTRB   (PSTRB),
`endif
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_rd = '0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] s);
        logic [1:0] eff;
`ifdef APB_SLAVE_PSTRB_EN
        eff = s;
`else
        eff = 2'b11;
`endif
        if (a < DEPTH) begin
            for (int b = 0; b < 2; b++)
                if (eff[b]) model[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Drives one transfer; drop>0 releases PSEL before that PENABLE cycle.
    // PENABLE cycle 1 is the SETUP state, the ACCESS state spans cycles 2..WS+2.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [1:0] s, input int drop,
                        output bit rdy, output int ncyc, output logic [DW-1:0] rd, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        rdy = 1'b0; ncyc = 0; rd = '0; err = 1'b0;
        for (int n = 1; n <= WS + 6; n++) begin
            if (n > 1) begin @(posedge PCLK); #1; end
            if (n >= 2) begin
                PADDR = AW'($urandom); PWDATA = DW'($urandom); PWRITE = 1'($urandom);
            end
            if (n == drop) begin PSEL = 1'b0; PENABLE = 1'b0; end
            @(negedge PCLK);
            if (PREADY) begin
                rdy = 1'b1; ncyc = n; rd = PRDATA; err = PSLVERR;
                break;
            end
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [1:0] s, input string tag, output logic [DW-1:0] rd);
        bit rdy; int n; logic err; logic [DW-1:0] exp;
        xfer(wr, a, d, s, 0, rdy, n, rd, err);
        check({tag, "/ready"}, 32'(rdy), 32'd1);
        check({tag, "/cycles"}, 32'(n), 32'(WS + 2));
        check({tag, "/slverr"}, 32'(err), 32'(a >= DEPTH));
        if (wr) begin
            check({tag, "/prdata_hold"}, 32'(rd), 32'(last_rd));
            model_write(a, d, s);
        end else begin
            exp = (a < DEPTH) ? model[a] : '0;
            check({tag, "/prdata"}, 32'(rd), 32'(exp));
            last_rd = exp;
        end
    endtask

    task automatic sweep(input string tag);
        logic [DW-1:0] rd;
        for (int i = 0; i < DEPTH; i++) do_xfer(1'b0, AW'(i), '0, 2'b00, tag, rd);
    endtask

    initial begin
        logic [DW-1:0] rd;
        bit rdy; int n; logic err;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = 2'b00;
        model_clear();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst/pready", 32'(PREADY), 32'd0);
        check("rst/pslverr", 32'(PSLVERR), 32'd0);
        check("rst/prdata", 32'(PRDATA), 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // First transfer straight out of reset, then read back
        do_xfer(1'b1, 8'h00, 16'hFFFF, 2'b11, "w0", rd);
        do_xfer(1'b0, 8'h00, 16'h0000, 2'b00, "r0", rd);
        check("r0/const", 32'(rd), 32'h0000FFFF);

        do_xfer(1'b1, 8'h01, 16'hEACF, 2'b11, "w1", rd);
        do_xfer(1'b0, 8'h00, 16'h0000, 2'b00, "r0b", rd);
        check("r0b/const", 32'(rd), 32'h0000FFFF);
        do_xfer(1'b0, 8'h01, 16'h0000, 2'b00, "r1", rd);
        check("r1/const", 32'(rd), 32'h0000EACF);

        // PENABLE without a setup cycle must not start a transfer
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("noset/pready", 32'(PREADY), 32'd0);
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0;

        // Out-of-range access
        do_xfer(1'b1, 8'h20, 16'h1234, 2'b11, "werr", rd);
        sweep("werr_sweep");
        do_xfer(1'b0, 8'h20, 16'h0000, 2'b00, "rerr", rd);
        check("rerr/const", 32'(rd), 32'd0);

        do_xfer(1'b1, 8'h02, 16'h1234, 2'b11, "w2a", rd);
        do_xfer(1'b1, 8'h02, 16'hABCD, 2'b10, "w2b", rd);
        do_xfer(1'b0, 8'h02, 16'h0000, 2'b01, "r2", rd);
`ifdef APB_SLAVE_PSTRB_EN
        check("r2/strobe", 32'(rd), 32'h0000AB34);
        do_xfer(1'b1, 8'h02, 16'h5A5A, 2'b00, "w2z", rd);
        do_xfer(1'b0, 8'h02, 16'h0000, 2'b00, "r2z", rd);
        check("r2z/nochange", 32'(rd), 32'h0000AB34);
`else
        check("r2/fullword", 32'(rd), 32'h0000ABCD);
`endif

        // PSEL dropped in the 2nd ACCESS cycle (PENABLE cycle 3)
        xfer(1'b1, 8'h03, 16'h5555, 2'b11, 3, rdy, n, rd, err);
        check("abort/ready", 32'(rdy), 32'd0);
        do_xfer(1'b0, 8'h03, 16'h0000, 2'b00, "r3", rd);
        check("r3/const", 32'(rd), 32'd0);

        // Reset pulsed mid-wait of a write, while PRDATA holds a nonzero value
        do_xfer(1'b0, 8'h01, 16'h0000, 2'b00, "r1pre", rd);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 16'h7777; PSTRB = 2'b11;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        check("midrst/prdata_before", 32'(PRDATA), 32'h0000EACF);
        PRESET = 1'b1;
        #1;
        check("midrst/pready", 32'(PREADY), 32'd0);
        check("midrst/pslverr", 32'(PSLVERR), 32'd0);
        check("midrst/prdata", 32'(PRDATA), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        model_clear();
        sweep("rst_sweep");
        do_xfer(1'b1, 8'h04, 16'h0F0F, 2'b11, "w4", rd);
        do_xfer(1'b0, 8'h04, 16'h0000, 2'b00, "r4", rd);
        check("r4/const", 32'(rd), 32'h00000F0F);

        // Random traffic against the model, including out-of-range addresses
        for (int i = 0; i < 60; i++) begin
            do_xfer(1'($urandom), AW'($urandom_range(0, 23)), DW'($urandom),
                    2'($urandom), "rand", rd);
        end
        sweep("final_sweep");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
